uart_cmd_ctrl: RTL

Command front-end that sits directly upstream of the UART command/transmit block. It buffers host register-access commands in a FIFO and issues them one at a time over the UART's cmd_vld/cmd_rdy handshake. For read commands it collects the UART's read_rdy/read_data result and returns a tagged response to the host. If no read result arrives in time, it returns a timeout response instead.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_cmd_fifo.sv | 63 ++++++
 rtl/uart_cmd_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command front-end.
// Holds the command word field positions, default clock/baud constants and the
// controller state encoding. State codes are plain localparams on a 3-bit type
// so older tools and waveform scripts that expect fixed codes keep working.
package uart_pkg;

  // Command word layout: {wr, addr[6:0], wdata[7:0]}
  localparam int unsigned WR_BIT   = 15;
  localparam int unsigned ADDR_MSB = 14;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;

  // Defaults of the downstream UART block
  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned BAUD_RATE   = 115_200;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t ISSUE     = 3'd1;
  localparam state_t WAIT_DONE = 3'd2;
  localparam state_t WAIT_RSP  = 3'd3;
  localparam state_t RESP      = 3'd4;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous FIFO for queued host commands.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   push      - write request; ignored while full
//   wdata     - data to write
//   pop       - read request; ignored while empty
//   rdata     - head entry (valid while not empty)
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - current occupancy
// DEPTH must be a power of 2 (>= 2) so the pointers wrap by overflow.
module uart_cmd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command front-end for the UART command/transmit block.
// Buffers host register-access commands, issues them one at a time over the
// cmd_vld/cmd_rdy style handshake and returns a tagged response for reads
// (read data, parity error, or timeout).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   host_cmd/vld    - host command in; host_rdy = FIFO not full
//   uart_cmd/vld    - command to UART, uart_vld is a one-cycle issue pulse
//   uart_rdy        - UART idle; drops while a frame is in flight
//   uart_read_rdy   - read result strobe, uart_read_data = {parity_err, data}
//   rsp_*           - one-cycle read response (addr, data, err, timeout)
//   busy            - FSM not idle or commands queued
//   fifo_count      - FIFO occupancy
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CMD_WIDTH  = 16,
  parameter int unsigned READ_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TO_CYCLES  = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CMD_WIDTH-1:0]          host_cmd,
  input  logic                          host_vld,
  output logic                          host_rdy,
  output logic [CMD_WIDTH-1:0]          uart_cmd,
  output logic                          uart_vld,
  input  logic                          uart_rdy,
  input  logic                          uart_read_rdy,
  input  logic [READ_WIDTH:0]           uart_read_data,
  output logic                          rsp_vld,
  output logic [6:0]                    rsp_addr,
  output logic [READ_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);
  // The counter starts at 2 so that the RESP cycle and the registered rsp_vld
  // cycle are included: rsp_vld lands exactly TO_CYCLES cycles after uart_vld.
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(2);

  state_t                state_q, state_d;
  logic [CMD_WIDTH-1:0]  cmd_q;
  logic                  uart_vld_q;
  logic                  seen_low_q;
  logic                  got_rsp_q;
  logic                  to_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic [READ_WIDTH:0]   rdata_q;
  logic                  rsp_vld_q;
  logic [6:0]            rsp_addr_q;
  logic [READ_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  logic [CMD_WIDTH-1:0]  fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  is_read;
  logic                  in_wait;
  logic                  to_fire;
  logic                  capture;

  assign push     = host_vld && !fifo_full;
  assign pop      = (state_q == IDLE) && !fifo_empty;
  assign host_rdy = !fifo_full;

  uart_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (host_cmd),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign is_read = !cmd_q[WR_BIT];
  assign in_wait = (state_q == WAIT_DONE) || (state_q == WAIT_RSP);
  assign to_fire = in_wait && is_read && !got_rsp_q && (to_cnt_q == TO_LIMIT);
  // A strobe coinciding with the timeout is dropped so a timed-out response
  // never carries stale parity.
  assign capture = in_wait && is_read && uart_read_rdy && !got_rsp_q && !to_fire;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        if (uart_rdy) begin
          issue   = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (to_fire) begin
          state_d = RESP;
        end else if (seen_low_q && uart_rdy) begin
          state_d = is_read ? WAIT_RSP : IDLE;
        end
      end
      WAIT_RSP: begin
        if (got_rsp_q || to_fire) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      uart_vld_q    <= 1'b0;
      seen_low_q    <= 1'b0;
      got_rsp_q     <= 1'b0;
      to_q          <= 1'b0;
      to_cnt_q      <= '0;
      rdata_q       <= '0;
      rsp_vld_q     <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      uart_vld_q <= issue;
      if (pop) cmd_q <= fifo_rdata;

      if (issue) begin
        seen_low_q <= 1'b0;
        got_rsp_q  <= 1'b0;
        to_q       <= 1'b0;
        rdata_q    <= '0;
        if (is_read) to_cnt_q <= TO_LOAD;
      end else begin
        if ((state_q == WAIT_DONE) && !uart_rdy) seen_low_q <= 1'b1;
        if (capture) begin
          got_rsp_q <= 1'b1;
          rdata_q   <= uart_read_data;
        end
        if (to_fire) to_q <= 1'b1;
        if (in_wait && is_read && (to_cnt_q != TO_LIMIT)) to_cnt_q <= to_cnt_q + 1'b1;
      end

      rsp_vld_q <= (state_q == RESP);
      if (state_q == RESP) begin
        rsp_addr_q    <= cmd_q[ADDR_MSB:ADDR_LSB];
        rsp_data_q    <= to_q ? '0 : rdata_q[READ_WIDTH-1:0];
        rsp_err_q     <= rdata_q[READ_WIDTH];
        rsp_timeout_q <= to_q;
      end
    end
  end

  assign uart_cmd    = cmd_q;
  assign uart_vld    = uart_vld_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule
